// File: rtl/complex_acc_frame_if.sv
// Product-in / frame-sum-out stream bundle for complex_acc_frame.
// master drives products and takes sums; slave is the accumulator.
interface complex_acc_frame_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FRAME_LEN  = 4,
   parameter int GUARD      = 4
);
   localparam int ACC_W = 2*DATA_WIDTH + GUARD;
   localparam int CNT_W = $clog2(FRAME_LEN+1);

   logic                    in_val;
   logic                    in_ready;
   logic [4*DATA_WIDTH-1:0] in_data;
   logic                    in_last;
   logic                    out_val;
   logic                    out_ready;
   logic [2*ACC_W-1:0]      out_data;
   logic [CNT_W-1:0]        out_count;

   modport master (
      output in_val, in_data, in_last, out_ready,
      input  in_ready, out_val, out_data, out_count
   );

   modport slave (
      input  in_val, in_data, in_last, out_ready,
      output in_ready, out_val, out_data, out_count
   );
endinterface

// File: rtl/complex_acc_frame.sv
// Accumulates a stream of complex products into one widened complex sum per frame.
//
// state | meaning
// ACCUM | accepting products, adding them into acc_re/acc_im
// HOLD  | frame sum presented on out_data until the consumer takes it
module complex_acc_frame #(
   parameter int DATA_WIDTH = 8,
   parameter int FRAME_LEN  = 4,
   parameter int GUARD      = 4,
   parameter int CNT_W      = $clog2(FRAME_LEN+1)
) (
   input logic                 clk,
   input logic                 sw_rst,
   complex_acc_frame_if.slave  bus
);
   localparam int PW    = 2*DATA_WIDTH;
   localparam int ACC_W = PW + GUARD;

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   state_t               state;
   logic [ACC_W-1:0]     acc_re;
   logic [ACC_W-1:0]     acc_im;
   logic [CNT_W-1:0]     cnt;
   logic [2*ACC_W-1:0]   out_data_r;
   logic [CNT_W-1:0]     out_count_r;
   logic                 out_val_r;

   logic signed [PW-1:0] prod_re;
   logic signed [PW-1:0] prod_im;
   logic [ACC_W-1:0]     sum_re;
   logic [ACC_W-1:0]     sum_im;
   logic                 accept;
   logic                 close;

   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_val   = out_val_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_count = out_count_r;

   always_comb begin
      prod_re = bus.in_data[2*PW-1:PW];
      prod_im = bus.in_data[PW-1:0];
      // signed cast sign-extends each part into the guard bits
      sum_re  = acc_re + ACC_W'(prod_re);
      sum_im  = acc_im + ACC_W'(prod_im);
      accept  = bus.in_val && (state == ACCUM);
      close   = (cnt == CNT_W'(FRAME_LEN-1)) || bus.in_last;
   end

   always_ff @(posedge clk) begin
      if (sw_rst) begin
         state       <= ACCUM;
         acc_re      <= '0;
         acc_im      <= '0;
         cnt         <= '0;
         out_data_r  <= '0;
         out_count_r <= '0;
         out_val_r   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  if (close) begin
                     out_data_r  <= {sum_re, sum_im};
                     out_count_r <= cnt + CNT_W'(1);
                     out_val_r   <= 1'b1;
                     acc_re      <= '0;
                     acc_im      <= '0;
                     cnt         <= '0;
                     state       <= HOLD;
                  end else begin
                     acc_re <= sum_re;
                     acc_im <= sum_im;
                     cnt    <= cnt + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_val_r <= 1'b0;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_complex_acc_frame.sv
// Directed bench for complex_acc_frame: frame-level model checked every cycle plus literal sums.
module tb_complex_acc_frame;
   localparam int DW    = 8;
   localparam int FL    = 4;
   localparam int GD    = 4;
   localparam int ACC_W = 2*DW + GD;

   logic clk = 1'b0;
   logic sw_rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   chk_en  = 0;

   complex_acc_frame_if #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .GUARD(GD)) bus ();

   complex_acc_frame #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .GUARD(GD)) dut (
      .clk    (clk),
      .sw_rst (sw_rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pk(input int re, input int im);
      return {re[15:0], im[15:0]};
   endfunction

   // Frame-level model: running complex sum of the accepted products.
   bit               m_hold = 0;
   int               m_re = 0, m_im = 0, m_cnt = 0;
   logic [2*ACC_W-1:0] m_out_data = '0;
   int               m_out_count = 0;

   always @(posedge clk) begin
      if (sw_rst) begin
         m_hold = 0; m_re = 0; m_im = 0; m_cnt = 0;
         m_out_data = '0; m_out_count = 0;
      end else if (m_hold) begin
         if (bus.out_ready) m_hold = 0;
      end else if (bus.in_val) begin
         m_re  = m_re + int'($signed(bus.in_data[31:16]));
         m_im  = m_im + int'($signed(bus.in_data[15:0]));
         m_cnt = m_cnt + 1;
         if (m_cnt == FL || bus.in_last) begin
            m_out_data  = {m_re[ACC_W-1:0], m_im[ACC_W-1:0]};
            m_out_count = m_cnt;
            m_hold = 1; m_re = 0; m_im = 0; m_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready",  64'(bus.in_ready),  64'(!m_hold));
         chk("out_val",   64'(bus.out_val),   64'(m_hold));
         chk("out_data",  64'(bus.out_data),  64'(m_out_data));
         chk("out_count", 64'(bus.out_count), 64'(m_out_count));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input int re, input int im, input bit last);
      bit acc = 0;
      bus.in_val  = 1'b1;
      bus.in_data = pk(re, im);
      bus.in_last = last;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk); #1;
      end
      if (!acc) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, required 1");
      end
      bus.in_val  = 1'b0;
      bus.in_last = 1'b0;
   endtask

   task automatic sum_chk(input string name, input logic [ACC_W-1:0] re,
                          input logic [ACC_W-1:0] im, input int count);
      @(negedge clk);
      chk({name, "_val"},   64'(bus.out_val),   64'(1));
      chk({name, "_data"},  64'(bus.out_data),  64'({re, im}));
      chk({name, "_count"}, 64'(bus.out_count), 64'(count));
   endtask

   initial begin
      sw_rst        = 1'b1;
      bus.in_val    = 1'b1;
      bus.in_data   = pk(55, 66);
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk_en = 1;
      tick();
      sw_rst     = 1'b0;
      bus.in_val = 1'b0;
      @(negedge clk);
      chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
      chk("rst_out_val",   64'(bus.out_val),   64'(0));
      chk("rst_out_data",  64'(bus.out_data),  64'(0));
      chk("rst_out_count", 64'(bus.out_count), 64'(0));
      tick();

      // full frame, back to back
      send(100, 5, 0); send(-3, 1, 0); send(2, 2, 0); send(1, 1, 0);
      sum_chk("full", 20'h00064, 20'h00009, 4);
      tick();

      // early close, then a fresh frame from zero
      send(7, 0, 0); send(8, -1, 1);
      sum_chk("early", 20'h0000F, 20'hFFFFF, 2);
      tick();
      send(1, 2, 0); send(1, 2, 0); send(1, 2, 0); send(1, 2, 0);
      sum_chk("restart", 20'h00004, 20'h00008, 4);
      tick();

      // sign extension at full scale
      for (int i = 0; i < 4; i++) send(-32768, 32767, 0);
      sum_chk("sext", 20'hE0000, 20'h1FFFC, 4);
      tick();

      // in_last together with the terminal count
      send(1, 0, 0); send(1, 0, 0); send(1, 0, 0); send(1, 0, 1);
      sum_chk("last_tc", 20'h00004, 20'h00000, 4);
      tick();

      // backpressure with the next product waiting
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(1, 1, 0);
      bus.in_val  = 1'b1;
      bus.in_data = pk(3, -2);
      repeat (5) tick();
      chk("bp_held_data",  64'(bus.out_data),  64'({20'h00004, 20'h00004}));
      chk("bp_held_count", 64'(bus.out_count), 64'(4));
      bus.out_ready = 1'b1;
      send(3, -2, 0);
      send(1, 1, 0); send(1, 1, 0); send(1, 1, 0);
      sum_chk("bp_next", 20'h00006, 20'h00001, 4);
      tick();

      // reset in the middle of a frame
      send(10, 10, 0); send(10, 10, 0);
      sw_rst = 1'b1; tick(); sw_rst = 1'b0;
      for (int i = 0; i < 4; i++) send(1, 1, 0);
      sum_chk("midrst", 20'h00004, 20'h00004, 4);
      tick();

      // reset while holding a sum: it is never delivered
      bus.out_ready = 1'b0;
      send(5, 5, 1);
      sum_chk("hold_pre", 20'h00005, 20'h00005, 1);
      tick();
      sw_rst = 1'b1; bus.out_ready = 1'b1; tick(); sw_rst = 1'b0;
      @(negedge clk);
      chk("holdrst_val",  64'(bus.out_val),  64'(0));
      chk("holdrst_data", 64'(bus.out_data), 64'(0));
      repeat (3) tick();

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
